// File: rtl/multiplier_2x2_pkg.sv
// Shared constants for the 2x2 unsigned multiplier.
//   MULT2X2_OPERAND_W  : operand width (2)
//   MULT2X2_RESULT_W   : full-precision product width (4)
//   MULT2X2_RESULT_RST : value loaded into result by reset
package multiplier_2x2_pkg;
  localparam int MULT2X2_OPERAND_W = 2;
  localparam int MULT2X2_RESULT_W  = 4;
  localparam logic [MULT2X2_RESULT_W-1:0] MULT2X2_RESULT_RST = 4'd0;
endpackage

// File: rtl/half_adder.sv
// One-bit half adder used inside the partial-product array.
//   a, b  : addend bits
//   sum   : a ^ b
//   carry : a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/multiplier_2x2.sv
// Registered unsigned 2-bit x 2-bit multiplier, gate-level partial-product
// array feeding an output register with a valid qualifier.
//   Clk          : rising-edge clock
//   Reset_n      : synchronous active-low reset
//   multiplicand : operand A (2 bits, unsigned)
//   multiplier   : operand B (2 bits, unsigned)
//   in_valid     : operands valid this cycle
//   result       : registered product A*B (4 bits, holds when no new product)
//   out_valid    : result carries a newly computed product this cycle
// Build option: define MULTIPLIER_2X2_INPUT_REG_EN to add an input register
// stage ahead of the array (latency 2 instead of 1).
module multiplier_2x2
  import multiplier_2x2_pkg::*;
(
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [MULT2X2_OPERAND_W-1:0] multiplicand,
  input  logic [MULT2X2_OPERAND_W-1:0] multiplier,
  input  logic                         in_valid,
  output logic [MULT2X2_RESULT_W-1:0]  result,
  output logic                         out_valid
);

  logic [MULT2X2_OPERAND_W-1:0] w_a, w_b;
  logic                         w_vld;

`ifdef MULTIPLIER_2X2_INPUT_REG_EN
  logic [MULT2X2_OPERAND_W-1:0] r_a, r_b;
  logic                         r_vld;

  // Operands only load with a valid beat, so idle (possibly X) inputs never
  // reach the array.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_a <= multiplicand;
        r_b <= multiplier;
      end
    end
  end

  assign w_a   = r_a;
  assign w_b   = r_b;
  assign w_vld = r_vld;
`else
  assign w_a   = multiplicand;
  assign w_b   = multiplier;
  assign w_vld = in_valid;
`endif

  // Partial products pp[i][j] = a[i] & b[j]
  logic w_pp00, w_pp01, w_pp10, w_pp11;
  assign w_pp00 = w_a[0] & w_b[0];
  assign w_pp01 = w_a[0] & w_b[1];
  assign w_pp10 = w_a[1] & w_b[0];
  assign w_pp11 = w_a[1] & w_b[1];

  logic w_p1, w_c1, w_p2, w_p3;

  half_adder u_ha1 (
    .a     (w_pp10),
    .b     (w_pp01),
    .sum   (w_p1),
    .carry (w_c1)
  );

  // Max product is 9, so the carry out of this stage is the MSB itself.
  half_adder u_ha2 (
    .a     (w_pp11),
    .b     (w_c1),
    .sum   (w_p2),
    .carry (w_p3)
  );

  logic [MULT2X2_RESULT_W-1:0] w_prod;
  assign w_prod = {w_p3, w_p2, w_p1, w_pp00};

  logic [MULT2X2_RESULT_W-1:0] r_result;
  logic                        r_out_valid;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_result    <= MULT2X2_RESULT_RST;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_vld;
      if (w_vld) r_result <= w_prod;
    end
  end

  assign result    = r_result;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_multiplier_2x2.sv
// Self-checking bench for multiplier_2x2: table sweep, hand-written corner
// sequences and randomized traffic against a delay-line model of A*B.
module tb_multiplier_2x2;

`ifdef MULTIPLIER_2X2_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] multiplicand = '0;
  logic [1:0] multiplier = '0;
  logic       in_valid = 1'b0;
  logic [3:0] result;
  logic       out_valid;

  multiplier_2x2 dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .in_valid     (in_valid),
    .result       (result),
    .out_valid    (out_valid)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a LAT-deep queue of {valid, product}; output shows the
  // oldest entry, result keeps the last valid product.
  typedef struct { logic v; int p; } ent_t;
  ent_t       pipe[$];
  logic [3:0] m_res;
  logic       m_vld;

  typedef struct { logic [1:0] a; logic [1:0] b; logic [3:0] exp; } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [3:0] got_r, input logic [3:0] exp_r,
                     input logic got_v, input logic exp_v);
    n_tests++;
    if (got_r !== exp_r || got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: result=%0d out_valid=%0b, want result=%0d out_valid=%0b",
               name, got_r, got_v, exp_r, exp_v);
    end
  endtask

  // Drive one cycle, advance the model on the edge and compare just after it.
  task automatic step(input logic rst_n, input logic v, input logic [1:0] a, input logic [1:0] b);
    ent_t e;
    @(negedge Clk);
    Reset_n = rst_n; in_valid = v; multiplicand = a; multiplier = b;
    @(posedge Clk);
    if (!rst_n) begin
      pipe.delete();
      for (int i = 0; i < LAT - 1; i++) pipe.push_back('{v: 1'b0, p: 0});
      m_res = 4'd0;
      m_vld = 1'b0;
    end else begin
      pipe.push_back('{v: v, p: int'(a) * int'(b)});
      e = pipe.pop_front();
      m_vld = e.v;
      if (e.v) m_res = 4'(e.p);
    end
    #1;
    chk("model", result, m_res, out_valid, m_vld);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd1, 2'd1);
  endtask

  initial begin
    logic [3:0] bb_exp[3];
    logic [1:0] bb_op[3];

    for (int i = 0; i < 16; i++) begin
      vecs[i].a   = 2'(i / 4);
      vecs[i].b   = 2'(i % 4);
      vecs[i].exp = 4'((i / 4) * (i % 4));
    end
    bb_op[0] = 2'd1; bb_op[1] = 2'd2; bb_op[2] = 2'd3;
    bb_exp[0] = 4'd1; bb_exp[1] = 4'd4; bb_exp[2] = 4'd9;

    // Reset state
    step(1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b0, 1'b1, 2'd3, 2'd3);
    chk("reset_state", result, 4'd0, out_valid, 1'b0);

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, vecs[i].a, vecs[i].b);
      idle(LAT - 1);
      chk($sformatf("sweep_%0dx%0d", vecs[i].a, vecs[i].b), result, vecs[i].exp, out_valid, 1'b1);
    end

    // Hold: load 3x2, then idle with 1x1 on the operands
    step(1'b1, 1'b1, 2'd3, 2'd2);
    idle(LAT - 1);
    chk("hold_load", result, 4'd6, out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("hold_idle", result, 4'd6, out_valid, 1'b0);
    end

    // Back-to-back 1x1, 2x2, 3x3
    for (int k = 0; k < 3 + LAT - 1; k++) begin
      if (k < 3) step(1'b1, 1'b1, bb_op[k], bb_op[k]);
      else       idle(1);
      if (k >= LAT - 1)
        chk($sformatf("b2b_%0d", k - LAT + 1), result, bb_exp[k - LAT + 1], out_valid, 1'b1);
    end

    // Reset priority over a valid 3x3 on the same edge
    step(1'b0, 1'b1, 2'd3, 2'd3);
    chk("rst_prio", result, 4'd0, out_valid, 1'b0);
    for (int i = 0; i < LAT + 1; i++) begin
      idle(1);
      chk("rst_no9", result, 4'd0, out_valid, 1'b0);
    end
    step(1'b1, 1'b1, 2'd2, 2'd1);
    idle(LAT - 1);
    chk("post_rst_2x1", result, 4'd2, out_valid, 1'b1);

    // Reset mid-stream discards an in-flight 3x3
    step(1'b1, 1'b1, 2'd3, 2'd3);
    step(1'b0, 1'b0, 2'd0, 2'd0);
    chk("mid_rst", result, 4'd0, out_valid, 1'b0);
    idle(LAT);
    chk("mid_rst_flush", result, 4'd0, out_valid, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) != 0), 1'($urandom), 2'($urandom), 2'($urandom));
    idle(LAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
